// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target.
package sccb_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ID,
      ID_ACK,
      SUB,
      SUB_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RD_NA,
      WAIT_STOP
   } sccb_tgt_state_t;

   // Bit counter value while the 9th (acknowledge) clock is in progress.
   localparam logic [3:0] ACK_BIT_IDX   = 4'd8;
   localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/sccb_edge_sync.sv
// Two-flop synchronizer plus registered edge detector for one bus line.
module sccb_edge_sync (
   input  logic clk_25,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1, s2, prev;

   // Flops reset to 1 so an idle (pulled-up) bus produces no edge after reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
         rise <= s2 & ~prev;
         fall <= ~s2 & prev;
      end
   end

   // prev updates on the same edge as rise/fall, so level is aligned with the edge pulses.
   assign level = prev;

endmodule

// File: rtl/sccb_target.sv
// SCCB camera-side target: decodes 3-phase writes and 2-phase reads, drives ACK/read data open-drain.
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [7:0] DEV_ID = 8'h42
) (
   input  logic       clk_25,
   input  logic       rst_n,
   input  logic       scl,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       reg_wr_en,
   output logic [7:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy,
   output logic       id_err
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

   sccb_edge_sync u_scl_sync (
      .clk_25 (clk_25),
      .rst_n  (rst_n),
      .din    (scl),
      .level  (scl_lvl),
      .rise   (scl_rise),
      .fall   (scl_fall)
   );

   sccb_edge_sync u_sda_sync (
      .clk_25 (clk_25),
      .rst_n  (rst_n),
      .din    (sda_i),
      .level  (sda_lvl),
      .rise   (sda_rise),
      .fall   (sda_fall)
   );

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   sccb_tgt_state_t state, state_d;
   logic [3:0] bit_cnt, bit_cnt_d;
   logic [7:0] shift, shift_d, shift_in;
   logic [7:0] ptr_d, wr_addr_d, wr_data_d;
   logic       rw, rw_d;
   logic       sda_oe_d, wr_en_d, busy_d, id_err_d;
   logic       ack_state;

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         rw          <= 1'b0;
         rd_addr     <= '0;
         sda_oe      <= 1'b0;
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
         busy        <= 1'b0;
         id_err      <= 1'b0;
      end else begin
         state       <= state_d;
         bit_cnt     <= bit_cnt_d;
         shift       <= shift_d;
         rw          <= rw_d;
         rd_addr     <= ptr_d;
         sda_oe      <= sda_oe_d;
         reg_wr_en   <= wr_en_d;
         reg_wr_addr <= wr_addr_d;
         reg_wr_data <= wr_data_d;
         busy        <= busy_d;
         id_err      <= id_err_d;
      end
   end

   assign ack_state = (state == ID_ACK) || (state == SUB_ACK) || (state == WDATA_ACK);

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d   = state;
      bit_cnt_d = bit_cnt;
      shift_d   = shift;
      rw_d      = rw;
      ptr_d     = rd_addr;
      sda_oe_d  = sda_oe;
      wr_en_d   = 1'b0;
      wr_addr_d = reg_wr_addr;
      wr_data_d = reg_wr_data;
      busy_d    = busy;
      id_err_d  = 1'b0;
      shift_in  = {shift[6:0], sda_lvl};

      if (start_det) begin
         state_d   = ID;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b1;
      end else if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (ack_state) begin
         // Fall after the 8th bit drives ACK; fall after the 9th bit releases it and exits.
         if (scl_rise && bit_cnt == ACK_BIT_IDX) begin
            bit_cnt_d = ACK_BIT_IDX + 4'd1;
         end else if (scl_fall && bit_cnt == ACK_BIT_IDX) begin
            sda_oe_d = 1'b1;
         end else if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            case (state)
               ID_ACK: begin
                  if (rw) begin
                     state_d  = RDATA;
                     shift_d  = rd_data;
                     sda_oe_d = ~rd_data[7];
                  end else begin
                     state_d = SUB;
                  end
               end
               SUB_ACK: state_d = WDATA;
               default: begin
                  state_d = WDATA;
                  ptr_d   = rd_addr + 8'd1;
               end
            endcase
         end
      end else begin
         case (state)
            ID, SUB, WDATA: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt + 4'd1;
                  if (bit_cnt == BITS_PER_BYTE - 4'd1) begin
                     bit_cnt_d = ACK_BIT_IDX;
                     if (state == ID) begin
                        if (shift_in[7:1] == DEV_ID[7:1]) begin
                           state_d = ID_ACK;
                           rw_d    = shift_in[0];
                        end else begin
                           state_d  = WAIT_STOP;
                           id_err_d = 1'b1;
                        end
                     end else if (state == SUB) begin
                        state_d = SUB_ACK;
                        ptr_d   = shift_in;
                     end else begin
                        state_d   = WDATA_ACK;
                        wr_en_d   = 1'b1;
                        wr_addr_d = rd_addr;
                        wr_data_d = shift_in;
                     end
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
                  state_d  = RD_NA;
                  sda_oe_d = 1'b0;
               end else if (scl_fall && bit_cnt != '0) begin
                  shift_d  = {shift[6:0], 1'b0};
                  sda_oe_d = ~shift[6];
               end
            end
            RD_NA: begin
               if (scl_rise) begin
                  if (sda_lvl) begin
                     state_d = WAIT_STOP;
                  end else begin
                     ptr_d     = rd_addr + 8'd1;
                     bit_cnt_d = ACK_BIT_IDX + 4'd1;
                  end
               end else if (scl_fall && bit_cnt == ACK_BIT_IDX + 4'd1) begin
                  // Pointer moved on the ACK rise, so rd_data already reflects the next register.
                  state_d   = RDATA;
                  bit_cnt_d = '0;
                  shift_d   = rd_data;
                  sda_oe_d  = ~rd_data[7];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB target (camera side) for closed-loop simulation of the `sccb_if` initiator and for FPGA-to-FPGA SCCB links. It oversamples SIOC/SIOD on the 25 MHz system clock, decodes 3-phase write and 2-phase read transactions addressed to `DEV_ID`, and drives ACK and read-data bits on an open-drain SDA. Register storage is external: writes leave the block as a one-cycle strobe, and reads fetch from an external port.

## Interface
- `DEV_ID`, 8'h42: 7-bit write ID in bits [7:1]; bit 0 is ignored when matching.
- `clk_25`  in  1  system clock, ≥ 8× SCL frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scl`  in  1  SIOC from the initiator.
- `sda_i`  in  1  SIOD line value.
- `sda_oe`  out  1  1 = pull SIOD low; 0 = release. The bench resolves the line with a pull-up.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_wr_addr`  out  8  write sub-address.
- `reg_wr_data`  out  8  write data.
- `rd_addr`  out  8  current sub-address pointer.
- `rd_data`  in  8  external register value at `rd_addr`; sampled in the same cycle.
- `busy`  out  1  high from START until STOP or an abort.
- `id_err`  out  1  one-cycle pulse when the ID does not match.

## Operation
- `scl` and `sda_i` each pass through a 2-flop synchronizer, followed by a previous-value register for edge detection.
- Bus events:
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
- START is accepted in any state, including a repeated START. It clears the bit counter and enters `ID`.
- STOP is accepted in any state and enters `IDLE`. A partial byte is discarded and no write is issued.
- Data is sampled on SCL rising edges, MSB first. `sda_oe` changes only on detected SCL falling edges.
- FSM states: `IDLE`, `ID`, `ID_ACK`, `SUB`, `SUB_ACK`, `WDATA`, `WDATA_ACK`, `RDATA`, `RD_NA`, `WAIT_STOP`.
- `ID`:
  - After 8 bits, if ID[7:1] matches `DEV_ID[7:1]`, go to `ID_ACK` and drive `sda_oe`=1 for the 9th clock.
  - On mismatch, pulse `id_err`, keep `sda_oe`=0 and go to `WAIT_STOP`.
- `ID_ACK` exit:
  - If ID bit 0 = 0 (write), go to `SUB`.
  - If ID bit 0 = 1 (read), go to `RDATA`. On the same SCL fall that ends the ACK, load the shift register from `rd_data` and drive its MSB.
- `SUB`: 8 bits are loaded into the address pointer; ACK follows, then `WDATA`.
- `WDATA`: after 8 bits, pulse `reg_wr_en` with `reg_wr_addr` = pointer and the received data. Then ACK, increment the pointer (wraps 0xFF→0x00) and return to `WDATA`.
- `RDATA`: `sda_oe` = ~shift[7] for each bit. After 8 bits, release SDA and go to `RD_NA` to sample the initiator's bit:
  - NA (1): go to `WAIT_STOP`.
  - ACK (0): increment the pointer, reload from `rd_data` and return to `RDATA`.
- A 2-phase write (ID + sub-address, then STOP) only sets the pointer; no write is issued.
- Reset values: `sda_oe`=0, `reg_wr_en`=0, `reg_wr_addr`=0, `reg_wr_data`=0, `rd_addr`=0, `busy`=0, `id_err`=0. The FSM resets to `IDLE` and all synchronizer flops reset to 1.

## Timing
- Pin change to internal event: 3 `clk_25` cycles (2 synchronizer + 1 edge-detect).
- `sda_oe` asserts 1 cycle after the detected SCL fall, i.e. 4 cycles after the pin edge.
- `reg_wr_en` asserts 1 cycle after the 8th data SCL rise is detected, and is high for exactly 1 cycle.
- `id_err` pulses 1 cycle after the 8th ID bit is sampled.
- `busy` rises 1 cycle after START is detected and falls 1 cycle after STOP is detected.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronous). After release, the block ignores the bus until the next START.
- START and STOP detected in the same cycle cannot occur: each needs an SDA edge of opposite sign.

## Structure
- `sccb_pkg` holds:
  - the FSM state enum `sccb_tgt_state_t`;
  - constants for the ACK bit index (8) and bits per byte (8).
- Sub-module `sccb_edge_sync`: 2-flop synchronizer plus edge detector for one signal, outputting `level`, `rise` and `fall`. It is instantiated once for `scl` and once for `sda_i`.
- The bench pairs `sccb_if` with `sccb_target` and a 256×8 register array. The shared SDA is resolved as wired-AND.

## Test plan
- 3-phase write ID 0x42, sub 0x12, data 0x80 → one `reg_wr_en` pulse with addr 0x12, data 0x80; ACK low on all three 9th bits.
- ID 0x60 → `id_err` pulse, `sda_oe` stays 0 through STOP, no write.
- Write sub 0x0A then STOP; read ID 0x43 with `rd_data`=0x76 → SDA bits 0,1,1,1,0,1,1,0; SDA released at the NA bit; `busy` falls after STOP.
- Burst write sub 0xFF, data 0x11, 0x22 → writes (0xFF,0x11) then (0x00,0x22).
- Repeated START after the sub-address → FSM back in `ID`; a read returns the register at the new pointer.
- `rst_n` low mid-`WDATA`, or STOP after 4 data bits → no `reg_wr_en`, `sda_oe`=0, FSM in `IDLE`.
